// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage pipeline.
// The execute-stage outputs are registered into R. Word and byte loads and
// stores are issued over a req/ack data-memory handshake. Upstream is held
// while an access is outstanding. A registered write-back bundle W goes to WB.
module mem_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_MEM_dmemWe,
    input  logic          i_MEM_regWe,
    input  logic          i_MEM_sByte,
    input  logic          i_MEM_sWRD,
    input  logic [4:0]    i_MEM_WRA,
    input  logic [DW-1:0] i_MEM_rd2,
    input  logic [DW-1:0] i_MEM_aluOut,
    output logic          o_MEM_stall,
    output logic          o_MEM_req,
    output logic          o_MEM_we,
    output logic [DW-1:0] o_MEM_addr,
    output logic [DW-1:0] o_MEM_wdata,
    output logic [3:0]    o_MEM_wstrb,
    input  logic          i_MEM_ack,
    input  logic [DW-1:0] i_MEM_rdata,
    output logic          o_MEM_regWe,
    output logic [4:0]    o_MEM_WRA,
    output logic [DW-1:0] o_MEM_wbData,
    output logic          o_MEM_exc
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Input register R (all-zero contents form a bubble)
    logic          r_dmemWe;
    logic          r_regWe;
    logic          r_sByte;
    logic          r_sWRD;
    logic [4:0]    r_WRA;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_aluOut;

    // Handshake FSM
    state_t        r_state;
    state_t        w_state_n;

    // Output register W
    logic          r_wRegWe;
    logic [4:0]    r_wWRA;
    logic [DW-1:0] r_wData;
    logic          r_wExc;

    logic          w_wRegWe_n;
    logic [4:0]    w_wWRA_n;
    logic [DW-1:0] w_wData_n;
    logic          w_wExc_n;

    // Decoded operation
    logic          w_store;
    logic          w_load;
    logic          w_memop;
    logic          w_misaligned;
    logic          w_access;
    logic          w_stall;
    logic [7:0]    w_ldByte;
    logic [DW-1:0] w_ldData;

    // Capture execute-stage outputs unless the stage is stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dmemWe <= 1'b0;
            r_regWe  <= 1'b0;
            r_sByte  <= 1'b0;
            r_sWRD   <= 1'b0;
            r_WRA    <= '0;
            r_rd2    <= '0;
            r_aluOut <= '0;
        end else if (!w_stall) begin
            r_dmemWe <= i_MEM_dmemWe;
            r_regWe  <= i_MEM_regWe;
            r_sByte  <= i_MEM_sByte;
            r_sWRD   <= i_MEM_sWRD;
            r_WRA    <= i_MEM_WRA;
            r_rd2    <= i_MEM_rd2;
            r_aluOut <= i_MEM_aluOut;
        end
    end

    // Decode the held operation; a store takes priority over a load
    always_comb begin
        w_store      = r_dmemWe;
        w_load       = r_sWRD & ~r_dmemWe;
        w_memop      = w_store | w_load;
        w_misaligned = w_memop & ~r_sByte & (r_aluOut[1:0] != 2'b00);
        w_access     = w_memop & ~w_misaligned;
        w_stall      = w_access & ~i_MEM_ack;
    end

    // Memory request side; everything is held stable from R while waiting
    always_comb begin
        o_MEM_req   = w_access;
        o_MEM_stall = w_stall;
        o_MEM_we    = w_access & w_store;
        o_MEM_addr  = '0;
        o_MEM_wdata = '0;
        o_MEM_wstrb = '0;
        if (w_access) begin
            o_MEM_addr = {r_aluOut[DW-1:2], 2'b00};
        end
        if (w_access && w_store) begin
            if (r_sByte) begin
                o_MEM_wdata = {4{r_rd2[7:0]}};
                o_MEM_wstrb = 4'b0001 << r_aluOut[1:0];
            end else begin
                o_MEM_wdata = r_rd2;
                o_MEM_wstrb = 4'hF;
            end
        end
    end

    // Load data: little-endian lane select with sign extension for bytes
    always_comb begin
        w_ldByte = 8'h00;
        case (r_aluOut[1:0])
            2'd0:    w_ldByte = i_MEM_rdata[7:0];
            2'd1:    w_ldByte = i_MEM_rdata[15:8];
            2'd2:    w_ldByte = i_MEM_rdata[23:16];
            default: w_ldByte = i_MEM_rdata[31:24];
        endcase
        w_ldData = r_sByte ? {{(DW-8){w_ldByte[7]}}, w_ldByte} : i_MEM_rdata;
    end

    // Handshake state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state: leave IDLE only when the memory did not ack at once
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access && !i_MEM_ack) begin
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_MEM_ack) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Next write-back bundle: bubble on stall, exception on misalignment
    always_comb begin
        w_wRegWe_n = 1'b0;
        w_wWRA_n   = r_wWRA;
        w_wData_n  = r_wData;
        w_wExc_n   = 1'b0;
        if (w_stall) begin
            w_wRegWe_n = 1'b0;
        end else if (w_misaligned) begin
            w_wExc_n = 1'b1;
        end else begin
            w_wRegWe_n = r_regWe & ~w_store;
            w_wWRA_n   = r_WRA;
            w_wData_n  = w_load ? w_ldData : r_aluOut;
        end
    end

    // Write-back register, loaded every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wRegWe <= 1'b0;
            r_wWRA   <= '0;
            r_wData  <= '0;
            r_wExc   <= 1'b0;
        end else begin
            r_wRegWe <= w_wRegWe_n;
            r_wWRA   <= w_wWRA_n;
            r_wData  <= w_wData_n;
            r_wExc   <= w_wExc_n;
        end
    end

    // Registered write-back outputs
    always_comb begin
        o_MEM_regWe  = r_wRegWe;
        o_MEM_WRA    = r_wWRA;
        o_MEM_wbData = r_wData;
        o_MEM_exc    = r_wExc;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_stage;

    logic        clk;
    logic        rstn;
    logic        i_MEM_dmemWe;
    logic        i_MEM_regWe;
    logic        i_MEM_sByte;
    logic        i_MEM_sWRD;
    logic [4:0]  i_MEM_WRA;
    logic [31:0] i_MEM_rd2;
    logic [31:0] i_MEM_aluOut;
    logic        o_MEM_stall;
    logic        o_MEM_req;
    logic        o_MEM_we;
    logic [31:0] o_MEM_addr;
    logic [31:0] o_MEM_wdata;
    logic [3:0]  o_MEM_wstrb;
    logic        i_MEM_ack;
    logic [31:0] i_MEM_rdata;
    logic        o_MEM_regWe;
    logic [4:0]  o_MEM_WRA;
    logic [31:0] o_MEM_wbData;
    logic        o_MEM_exc;

    int unsigned n_pass;
    int unsigned n_total;

    mem_stage #(.DW(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_MEM_dmemWe(i_MEM_dmemWe),
        .i_MEM_regWe (i_MEM_regWe),
        .i_MEM_sByte (i_MEM_sByte),
        .i_MEM_sWRD  (i_MEM_sWRD),
        .i_MEM_WRA   (i_MEM_WRA),
        .i_MEM_rd2   (i_MEM_rd2),
        .i_MEM_aluOut(i_MEM_aluOut),
        .o_MEM_stall (o_MEM_stall),
        .o_MEM_req   (o_MEM_req),
        .o_MEM_we    (o_MEM_we),
        .o_MEM_addr  (o_MEM_addr),
        .o_MEM_wdata (o_MEM_wdata),
        .o_MEM_wstrb (o_MEM_wstrb),
        .i_MEM_ack   (i_MEM_ack),
        .i_MEM_rdata (i_MEM_rdata),
        .o_MEM_regWe (o_MEM_regWe),
        .o_MEM_WRA   (o_MEM_WRA),
        .o_MEM_wbData(o_MEM_wbData),
        .o_MEM_exc   (o_MEM_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one execute-stage bundle
    task automatic set_op(input logic we, input logic rwe, input logic sb,
                          input logic swrd, input logic [4:0] wra,
                          input logic [31:0] rd2, input logic [31:0] alu);
        i_MEM_dmemWe = we;
        i_MEM_regWe  = rwe;
        i_MEM_sByte  = sb;
        i_MEM_sWRD   = swrd;
        i_MEM_WRA    = wra;
        i_MEM_rd2    = rd2;
        i_MEM_aluOut = alu;
    endtask

    task automatic set_bubble();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_MEM_ack   = 1'b0;
        i_MEM_rdata = 32'h0;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h11, 32'h104);
        repeat (2) @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_stall, o_MEM_we, o_MEM_regWe, o_MEM_exc} !== 5'b0) begin
            $display("FAIL reset_ctrl: req/stall/we/regWe/exc=%b expected 00000",
                     {o_MEM_req, o_MEM_stall, o_MEM_we, o_MEM_regWe, o_MEM_exc});
        end else n_pass++;
        n_total++;
        if ({o_MEM_addr, o_MEM_wdata, o_MEM_wstrb, o_MEM_WRA, o_MEM_wbData} !== '0) begin
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h WRA=%0d wbData=%h expected all 0",
                     o_MEM_addr, o_MEM_wdata, o_MEM_wstrb, o_MEM_WRA, o_MEM_wbData);
        end else n_pass++;
        set_bubble();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_alu_pass();
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h1234);
        @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_stall} !== 2'b00) begin
            $display("FAIL alu_noreq: req/stall=%b expected 00", {o_MEM_req, o_MEM_stall});
        end else n_pass++;
        set_bubble();
        @(negedge clk);
        n_total++;
        if ({o_MEM_regWe, o_MEM_WRA, o_MEM_wbData} !== {1'b1, 5'd5, 32'h1234}) begin
            $display("FAIL alu_wb: regWe=%b WRA=%0d wbData=%h expected 1 5 00001234",
                     o_MEM_regWe, o_MEM_WRA, o_MEM_wbData);
        end else n_pass++;
        n_total++;
        if (o_MEM_req !== 1'b0) begin
            $display("FAIL alu_req_after: req=%b expected 0", o_MEM_req);
        end else n_pass++;
    endtask

    task automatic test_zero_wait_load();
        i_MEM_ack   = 1'b1;
        i_MEM_rdata = 32'hDEADBEEF;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h100);
        @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_wstrb, o_MEM_addr} !==
            {1'b1, 1'b0, 1'b0, 4'h0, 32'h100}) begin
            $display("FAIL zw_load_req: req=%b we=%b stall=%b wstrb=%h addr=%h expected 1 0 0 0 00000100",
                     o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_wstrb, o_MEM_addr);
        end else n_pass++;
        set_bubble();
        @(negedge clk);
        n_total++;
        if ({o_MEM_regWe, o_MEM_WRA, o_MEM_wbData} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
            $display("FAIL zw_load_wb: regWe=%b WRA=%0d wbData=%h expected 1 7 deadbeef",
                     o_MEM_regWe, o_MEM_WRA, o_MEM_wbData);
        end else n_pass++;
        i_MEM_ack = 1'b0;
    endtask

    task automatic test_store_word();
        i_MEM_ack = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'hCAFEF00D, 32'h0000_0348);
        @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_wstrb, o_MEM_addr, o_MEM_wdata} !==
            {1'b1, 1'b1, 1'b0, 4'hF, 32'h348, 32'hCAFEF00D}) begin
            $display("FAIL sw_req: req=%b we=%b stall=%b wstrb=%h addr=%h wdata=%h expected 1 1 0 f 00000348 cafef00d",
                     o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_wstrb, o_MEM_addr, o_MEM_wdata);
        end else n_pass++;
        set_bubble();
        @(negedge clk);
        n_total++;
        if ({o_MEM_regWe, o_MEM_exc} !== 2'b00) begin
            $display("FAIL sw_noreg: regWe/exc=%b expected 00", {o_MEM_regWe, o_MEM_exc});
        end else n_pass++;
        i_MEM_ack = 1'b0;
    endtask

    task automatic test_byte_store_wait();
        i_MEM_ack = 1'b0;
        set_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h000000AB, 32'h202);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++;
            if ({o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_wstrb, o_MEM_addr, o_MEM_wdata} !==
                {1'b1, 1'b1, 1'b1, 4'b0100, 32'h200, 32'hABABABAB}) begin
                $display("FAIL sb_wait%0d: req=%b we=%b stall=%b wstrb=%b addr=%h wdata=%h expected 1 1 1 0100 00000200 abababab",
                         c, o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_wstrb, o_MEM_addr, o_MEM_wdata);
            end else n_pass++;
            n_total++;
            if ({o_MEM_regWe, o_MEM_exc} !== 2'b00) begin
                $display("FAIL sb_bubble%0d: regWe/exc=%b expected 00", c, {o_MEM_regWe, o_MEM_exc});
            end else n_pass++;
            // The next op is offered while stalled; it must wait in front of R
            set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 32'h55);
        end
        i_MEM_ack = 1'b1;
        #1;
        n_total++;
        if ({o_MEM_req, o_MEM_stall} !== 2'b10) begin
            $display("FAIL sb_ack: req/stall=%b expected 10", {o_MEM_req, o_MEM_stall});
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_regWe} !== 2'b00) begin
            $display("FAIL sb_done: req/regWe=%b expected 00", {o_MEM_req, o_MEM_regWe});
        end else n_pass++;
        i_MEM_ack = 1'b0;
        set_bubble();
        @(negedge clk);
        n_total++;
        if ({o_MEM_regWe, o_MEM_WRA, o_MEM_wbData} !== {1'b1, 5'd9, 32'h55}) begin
            $display("FAIL sb_next_op: regWe=%b WRA=%0d wbData=%h expected 1 9 00000055",
                     o_MEM_regWe, o_MEM_WRA, o_MEM_wbData);
        end else n_pass++;
    endtask

    task automatic test_byte_load_sext();
        logic [31:0] alu_t [5];
        logic [31:0] rd_t  [5];
        logic [31:0] exp_t [5];
        alu_t = '{32'h103, 32'h103, 32'h100, 32'h101, 32'h102};
        rd_t  = '{32'h80000000, 32'h7F000000, 32'h000000C3, 32'h00001200, 32'h00AB0000};
        exp_t = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFFFFC3, 32'h00000012, 32'hFFFFFFAB};
        i_MEM_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_MEM_rdata = rd_t[k];
            set_op(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0, alu_t[k]);
            @(negedge clk);
            n_total++;
            if ({o_MEM_req, o_MEM_stall, o_MEM_addr} !== {1'b1, 1'b0, 32'h100}) begin
                $display("FAIL lb_req%0d: req=%b stall=%b addr=%h expected 1 0 00000100",
                         k, o_MEM_req, o_MEM_stall, o_MEM_addr);
            end else n_pass++;
            set_bubble();
            @(negedge clk);
            n_total++;
            if ({o_MEM_regWe, o_MEM_wbData} !== {1'b1, exp_t[k]}) begin
                $display("FAIL lb_data%0d: regWe=%b wbData=%h expected 1 %h",
                         k, o_MEM_regWe, o_MEM_wbData, exp_t[k]);
            end else n_pass++;
        end
        i_MEM_ack = 1'b0;
    endtask

    task automatic test_misaligned();
        i_MEM_ack = 1'b0;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h102);
        @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_stall, o_MEM_exc} !== 3'b000) begin
            $display("FAIL mis_req: req/stall/exc=%b expected 000", {o_MEM_req, o_MEM_stall, o_MEM_exc});
        end else n_pass++;
        set_bubble();
        @(negedge clk);
        n_total++;
        if ({o_MEM_exc, o_MEM_regWe} !== 2'b10) begin
            $display("FAIL mis_exc: exc/regWe=%b expected 10", {o_MEM_exc, o_MEM_regWe});
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_MEM_exc !== 1'b0) begin
            $display("FAIL mis_pulse: exc=%b expected 0", o_MEM_exc);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        i_MEM_ack   = 1'b0;
        i_MEM_rdata = 32'h12345678;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h100);
        @(negedge clk);
        n_total++;
        if ({o_MEM_req, o_MEM_stall} !== 2'b11) begin
            $display("FAIL rst_wait_pending: req/stall=%b expected 11", {o_MEM_req, o_MEM_stall});
        end else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_total++;
        if ({o_MEM_req, o_MEM_stall, o_MEM_regWe, o_MEM_exc, o_MEM_addr, o_MEM_WRA} !== '0) begin
            $display("FAIL rst_async: req=%b stall=%b regWe=%b exc=%b addr=%h WRA=%0d expected all 0",
                     o_MEM_req, o_MEM_stall, o_MEM_regWe, o_MEM_exc, o_MEM_addr, o_MEM_WRA);
        end else n_pass++;
        set_bubble();
        #1 rstn = 1'b1;
        i_MEM_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_total++;
            if ({o_MEM_req, o_MEM_regWe, o_MEM_wbData} !== {1'b0, 1'b0, 32'h0}) begin
                $display("FAIL rst_stale_ack%0d: req=%b regWe=%b wbData=%h expected 0 0 00000000",
                         c, o_MEM_req, o_MEM_regWe, o_MEM_wbData);
            end else n_pass++;
        end
        i_MEM_ack = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_alu_pass();
        test_zero_wait_load();
        test_store_word();
        test_byte_store_wait();
        test_byte_load_sext();
        test_misaligned();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
